// File: rtl/wb_rf_port_arbiter_pkg.sv
// Shared types for the regfile write-port arbiter: FSM encoding, r0 constant,
// and the width helper for the starvation counter.
// Latency: n/a. Backpressure: n/a.
package wb_rf_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // holding buffer empty
    ST_HOLD  = 2'd1,  // buffer full, WB keeps priority
    ST_FORCE = 2'd2   // buffer full and starved long enough: it owns the port
  } arb_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // The counter must be able to hold STARVE_LIMIT itself.
  function automatic int starve_cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wb_rf_port_arbiter_hold_buf.sv
// One-entry holding buffer for a MUL/DIV result waiting for the regfile port.
// Latency: load visible next cycle; kill/drain clear valid next cycle.
// Backpressure: none internally; the owner only loads when the buffer is empty.
// Ports: clk, rst (async active-low), load/load_rdc/load_wdata, kill, drain,
//        valid/rdc/data (buffer contents; rdc/data keep last value when empty).
module wb_hold_buf
  import wb_rf_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4:0]        load_rdc,
  input  logic [DATA_W-1:0] load_wdata,
  input  logic              kill,
  input  logic              drain,
  output logic              valid,
  output logic [4:0]        rdc,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      rdc   <= REG_ZERO;
      data  <= '0;
    end else begin
      if (kill || drain) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
        rdc   <= load_rdc;
        data  <= load_wdata;
      end
    end
  end

endmodule

// File: rtl/wb_rf_port_arbiter.sv
// Arbitrates the single regfile write port between the WB stage and MUL/DIV.
// Latency: WB fire -> rf_we 1 cycle; DIV handshake -> rf_we >= 2 cycles.
// Backpressure: div_ready only when buffer empty; pipe_ready drops for one
//   cycle when a buffered result has starved STARVE_LIMIT cycles.
// Ports: clk, rst (async active-low); pipe_* WB request; div_* MUL/DIV request;
//        rf_* registered write port; pend_* buffer state for hazard logic.
module wb_rf_port_arbiter
  import wb_rf_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [4:0]        pipe_rdc,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_ready,
  input  logic              div_valid,
  input  logic [4:0]        div_rdc,
  input  logic [DATA_W-1:0] div_wdata,
  output logic              div_ready,
  output logic              rf_we,
  output logic [4:0]        rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              pend_valid,
  output logic [4:0]        pend_rdc
);

  localparam int CNT_W = starve_cnt_w(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t        state;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  cnt_inc;

  logic              buf_valid;
  logic [4:0]        buf_rdc;
  logic [DATA_W-1:0] buf_data;

  logic wb_wr;      // WB fires and actually writes (not r0)
  logic in_hold;
  logic in_force;
  logic buf_load;
  logic buf_kill;
  logic buf_drain;

  assign div_ready  = (state == ST_IDLE);
  assign pipe_ready = (state != ST_FORCE);
  assign pend_valid = (state != ST_IDLE);
  assign pend_rdc   = buf_rdc;

  assign in_hold  = (state == ST_HOLD)  && buf_valid;
  assign in_force = (state == ST_FORCE) && buf_valid;
  assign wb_wr    = pipe_we && pipe_ready && (pipe_rdc != REG_ZERO);
  assign cnt_inc  = starve_cnt + 1'b1;

  // r0 results are accepted but never stored.
  assign buf_load  = div_valid && div_ready && (div_rdc != REG_ZERO);
  // A younger WB write to the same register makes the buffered value stale.
  assign buf_kill  = in_hold && wb_wr && (pipe_rdc == buf_rdc);
  // A WB fire to r0 leaves the port free, so the buffer drains that cycle.
  assign buf_drain = in_force || (in_hold && !wb_wr);

  wb_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .load_rdc   (div_rdc),
    .load_wdata (div_wdata),
    .kill       (buf_kill),
    .drain      (buf_drain),
    .valid      (buf_valid),
    .rdc        (buf_rdc),
    .data       (buf_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      rf_we      <= 1'b0;
      rf_wa      <= REG_ZERO;
      rf_wd      <= '0;
    end else begin
      rf_we <= 1'b0;
      if (in_force) begin
        rf_we      <= 1'b1;
        rf_wa      <= buf_rdc;
        rf_wd      <= buf_data;
        state      <= ST_IDLE;
        starve_cnt <= '0;
      end else if (wb_wr) begin
        rf_we <= 1'b1;
        rf_wa <= pipe_rdc;
        rf_wd <= pipe_wdata;
        if (in_hold) begin
          if (buf_kill) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= cnt_inc;
            if (cnt_inc == CNT_LIMIT) begin
              state <= ST_FORCE;
            end
          end
        end else if (buf_load) begin
          state <= ST_HOLD;
        end
      end else if (in_hold) begin
        rf_we      <= 1'b1;
        rf_wa      <= buf_rdc;
        rf_wd      <= buf_data;
        state      <= ST_IDLE;
        starve_cnt <= '0;
      end else if (buf_load) begin
        state <= ST_HOLD;
      end
    end
  end

endmodule

// File: tb/tb_wb_rf_port_arbiter.sv
// Directed bench for wb_rf_port_arbiter with hand-computed expectations.
// Latency: n/a. Backpressure: n/a.
module tb_wb_rf_port_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_rdc;
  logic [31:0] pipe_wdata;
  logic        pipe_ready;
  logic        div_valid;
  logic [4:0]  div_rdc;
  logic [31:0] div_wdata;
  logic        div_ready;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        pend_valid;
  logic [4:0]  pend_rdc;

  int checks;
  int failures;

  wb_rf_port_arbiter #(
    .STARVE_LIMIT (4),
    .DATA_W       (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_rdc   (pipe_rdc),
    .pipe_wdata (pipe_wdata),
    .pipe_ready (pipe_ready),
    .div_valid  (div_valid),
    .div_rdc    (div_rdc),
    .div_wdata  (div_wdata),
    .div_ready  (div_ready),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .pend_valid (pend_valid),
    .pend_rdc   (pend_rdc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; land 1ns after it so outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we    = 1'b0;
    pipe_rdc   = 5'd0;
    pipe_wdata = 32'h0;
    div_valid  = 1'b0;
    div_rdc    = 5'd0;
    div_wdata  = 32'h0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    idle_inputs();

    // Reset state
    step();
    step();
    chk("rst_rf_we",      32'(rf_we),      32'd0);
    chk("rst_rf_wa",      32'(rf_wa),      32'd0);
    chk("rst_rf_wd",      rf_wd,           32'd0);
    chk("rst_pend_valid", 32'(pend_valid), 32'd0);
    chk("rst_pend_rdc",   32'(pend_rdc),   32'd0);
    chk("rst_div_ready",  32'(div_ready),  32'd1);
    chk("rst_pipe_ready", 32'(pipe_ready), 32'd1);
    rst = 1'b1;
    step();

    // Reset mid-HOLD discards the buffered r5 result
    div_valid = 1'b1; div_rdc = 5'd5; div_wdata = 32'h55;
    step();
    idle_inputs();
    chk("hold5_pend_valid", 32'(pend_valid), 32'd1);
    chk("hold5_pend_rdc",   32'(pend_rdc),   32'd5);
    chk("hold5_div_ready",  32'(div_ready),  32'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst_rf_we",      32'(rf_we),      32'd0);
    chk("arst_pend_valid", 32'(pend_valid), 32'd0);
    chk("arst_div_ready",  32'(div_ready),  32'd1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("arst_no_r5_write", 32'(rf_we), 32'd0);
    end

    // Idle DIV: r7/DEADBEEF reaches the port two cycles after the handshake
    div_valid = 1'b1; div_rdc = 5'd7; div_wdata = 32'hDEADBEEF;
    step();
    idle_inputs();
    chk("div7_pend_valid", 32'(pend_valid), 32'd1);
    chk("div7_rf_we_early", 32'(rf_we),     32'd0);
    step();
    chk("div7_rf_we",      32'(rf_we),      32'd1);
    chk("div7_rf_wa",      32'(rf_wa),      32'd7);
    chk("div7_rf_wd",      rf_wd,           32'hDEADBEEF);
    chk("div7_pend_clear", 32'(pend_valid), 32'd0);
    step();
    chk("div7_we_drop",    32'(rf_we),      32'd0);
    chk("div7_wa_hold",    32'(rf_wa),      32'd7);
    chk("div7_wd_hold",    rf_wd,           32'hDEADBEEF);

    // Starvation: four WB writes to r4, then one forced write of r3/0x11
    div_valid = 1'b1; div_rdc = 5'd3; div_wdata = 32'h11;
    step();
    idle_inputs();
    pipe_we = 1'b1; pipe_rdc = 5'd4; pipe_wdata = 32'h44;
    for (int i = 0; i < 4; i++) begin
      chk("starve_pipe_ready", 32'(pipe_ready), 32'd1);
      step();
      chk("starve_wb_we", 32'(rf_we), 32'd1);
      chk("starve_wb_wa", 32'(rf_wa), 32'd4);
      chk("starve_wb_wd", rf_wd,      32'h44);
    end
    chk("force_pipe_ready", 32'(pipe_ready), 32'd0);
    chk("force_pend_valid", 32'(pend_valid), 32'd1);
    step();
    chk("force_rf_we",      32'(rf_we),      32'd1);
    chk("force_rf_wa",      32'(rf_wa),      32'd3);
    chk("force_rf_wd",      rf_wd,           32'h11);
    chk("force_pipe_rdy2",  32'(pipe_ready), 32'd1);
    chk("force_pend_clear", 32'(pend_valid), 32'd0);
    step();
    chk("resume_rf_we", 32'(rf_we), 32'd1);
    chk("resume_rf_wa", 32'(rf_wa), 32'd4);
    idle_inputs();
    step();

    // WAW kill: WB r9/0xBB supersedes buffered r9/0xAA
    div_valid = 1'b1; div_rdc = 5'd9; div_wdata = 32'hAA;
    step();
    idle_inputs();
    chk("waw_pend_rdc", 32'(pend_rdc), 32'd9);
    pipe_we = 1'b1; pipe_rdc = 5'd9; pipe_wdata = 32'hBB;
    step();
    idle_inputs();
    chk("waw_rf_we",      32'(rf_we),      32'd1);
    chk("waw_rf_wa",      32'(rf_wa),      32'd9);
    chk("waw_rf_wd",      rf_wd,           32'hBB);
    chk("waw_pend_valid", 32'(pend_valid), 32'd0);
    chk("waw_div_ready",  32'(div_ready),  32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("waw_no_aa_write", 32'(rf_we), 32'd0);
    end

    // r0 drop on both sides
    div_valid = 1'b1; div_rdc = 5'd0; div_wdata = 32'h77;
    pipe_we = 1'b1; pipe_rdc = 5'd0; pipe_wdata = 32'h66;
    step();
    idle_inputs();
    chk("r0_rf_we",      32'(rf_we),      32'd0);
    chk("r0_pend_valid", 32'(pend_valid), 32'd0);
    chk("r0_div_ready",  32'(div_ready),  32'd1);
    step();
    chk("r0_rf_we2",     32'(rf_we),      32'd0);
    chk("r0_pend_valid2", 32'(pend_valid), 32'd0);
    chk("r0_wa_hold",    32'(rf_wa),      32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_rf_port_arbiter.md
Name: wb_rf_port_arbiter

Overview:
- Shares the single register-file write port between the in-order WB stage and the out-of-band multi-cycle MUL/DIV unit.
- The WB stage has fixed priority. A one-entry holding buffer keeps a DIV result until the port is free.
- A starvation counter can back-pressure WB for one cycle so the buffered result drains.
- Handles WAW ordering: a younger WB write to the buffered destination cancels the buffered result. Exposes buffer state to the hazard/bypass logic.

Parameters:
- STARVE_LIMIT, 4: blocked cycles allowed for a buffered DIV result before it is forced onto the port. Legal range 1..15.
- DATA_W, 32: write-data width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- pipe_we  in  1  WB stage requests a regfile write this cycle (already qualified by wb_valid and no exception)
- pipe_rdc  in  5  WB destination register
- pipe_wdata  in  DATA_W  WB write data
- pipe_ready  out  1  port accepts the WB write this cycle; 0 stalls WB (feeds wb_ready_go)
- div_valid  in  1  DIV/MUL result available
- div_rdc  in  5  DIV/MUL destination register
- div_wdata  in  DATA_W  DIV/MUL result
- div_ready  out  1  holding buffer can accept a result
- rf_we  out  1  registered regfile write enable
- rf_wa  out  5  registered regfile write address
- rf_wd  out  DATA_W  registered regfile write data
- pend_valid  out  1  holding buffer holds a live result (hazard unit must stall readers of pend_rdc)
- pend_rdc  out  5  buffered destination register

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, buf_valid=0, starve_cnt=0, rf_we=0, rf_wa=0, rf_wd=0, pend_valid=0, pend_rdc=0. Reset mid-operation discards any buffered result.
- States:
  - IDLE: buffer empty.
  - HOLD: buffer full, WB has priority.
  - FORCE: buffer full and starve_cnt==STARVE_LIMIT.
- Handshakes:
  - div_ready = (state==IDLE).
  - A result is accepted on div_valid & div_ready and enters HOLD next cycle. Accept and drain never happen in the same cycle.
  - pipe_ready = (state!=FORCE).
  - A WB write fires when pipe_we & pipe_ready.
- r0 rule: a write with rdc==0 is treated as no write on either side. It produces rf_we=0, and a DIV result to r0 is accepted then dropped (buffer stays IDLE).
- Port grant, one per cycle, outputs registered next edge:
  1. FORCE: write the buffer to the port; go to IDLE; starve_cnt=0.
  2. Otherwise, if a WB write fires, write WB data. In HOLD with pipe_rdc==pend_rdc, the buffer is killed (WAW: WB is younger): go to IDLE; starve_cnt=0.
  3. Otherwise, in HOLD, write the buffer; go to IDLE; starve_cnt=0.
  4. Otherwise rf_we=0 next cycle.
- In HOLD, when the WB write wins on a different rdc: starve_cnt+1. Reaching STARVE_LIMIT moves the state to FORCE.
- Latency: div_valid handshake to rf_we is at least 2 cycles. WB fire to rf_we is 1 cycle.
- pend_valid = (state!=IDLE); pend_rdc holds the buffered rdc.
- rf_wa and rf_wd hold their last values when rf_we=0.

Decomposition:
- Shared package: state encoding (IDLE/HOLD/FORCE), REG_ZERO=5'd0, counter width derived from STARVE_LIMIT.
- Natural sub-module: wb_hold_buf, the one-entry holding buffer with valid, rdc, data and kill/load/drain controls.
- Arbitration and counter stay in the top level.

Test Plan:
- Reset mid-HOLD: DIV result to r5 accepted, rst pulsed low between edges → rf_we=0, pend_valid=0 and div_ready=1 immediately. No later write to r5.
- Idle DIV: div_valid with r7/0xDEADBEEF, pipe_we=0 → pend_valid=1 for one cycle, then rf_we=1, rf_wa=7, rf_wd=0xDEADBEEF two cycles after the handshake.
- Starvation: buffer holds r3/0x11, pipe_we=1 continuously to r4 → four WB writes issue, then pipe_ready=0 for exactly one cycle and rf_we writes r3/0x11. WB resumes next cycle.
- WAW kill: buffer holds r9/0xAA, WB writes r9/0xBB → rf_wa=9, rf_wd=0xBB. Buffer cleared, r9/0xAA is never written, div_ready=1 next cycle.
- r0 drop: div_valid to r0, pipe_we to r0 → rf_we stays 0, pend_valid stays 0.
